pc_redirect_ctrl: RTL and testbench
===================================

// Module: pc_redirect_ctrl
// PURPOSE
//  Next-PC and prediction-tracking stage sitting between the branch predictor (bpu) and fetch.
//  Selects the next fetch PC from interrupt, mispredict-repair, bpu prediction or sequential PC+4.
//  Queues every issued prediction until execute resolves it and repairs the PC on a mismatch.
//  Produces the bpu training feedback (last_jump/last_addr/last_need_predict).
// PARAMETERS
//  DEPTH     4             in-flight prediction FIFO entries (power of 2, >=2)
//  RESET_PC  32'h0000_0000 pc_o value after reset
// PORTS
//  clk                  in   1   core clock, rising edge
//  rst                  in   1   asynchronous, active-low reset
//  pc_en_i              in   1   fetch accepts pc_o this cycle (0 = hold)
//  pred_valid_i         in   1   decode-stage instr is JAL/B-type; bpu outputs are valid
//  inst_addr_i          in   32  address of that decode-stage instr
//  bp_result_i          in   1   bpu predicts taken
//  bp_jump_addr_i       in   32  bpu predicted target
//  ex_resolve_valid_i   in   1   execute resolves oldest in-flight control-transfer instr
//  ex_taken_i           in   1   actual direction
//  ex_target_i          in   32  actual taken target
//  int_assert_i         in   1   interrupt/exception redirect request
//  int_addr_i           in   32  interrupt/exception vector
//  pc_o                 out  32  current fetch address
//  fetch_kill_o         out  1   discard instr currently in fetch (taken prediction)
//  flush_o              out  1   flush IF/ID and ID/EX (mispredict or interrupt)
//  stall_o              out  1   FIFO full with a new prediction pending; front end must hold
//  last_jump_o          out  1   bpu feedback: resolved direction
//  last_addr_o          out  32  bpu feedback: resolved instr address
//  last_need_predict_o  out  1   bpu feedback valid strobe (one cycle)
//  occupancy_o          out  $clog2(DEPTH)+1  FIFO entries in use
//  err_o                out  1   sticky: resolve arrived with FIFO empty
// BEHAVIOUR
//  Reset (rst=0, async): pc_o=RESET_PC; FIFO empty; occupancy_o=0; err_o=0;
//    last_* outputs=0. Combinational outputs follow from the empty state.
//  FIFO entry = {addr[31:0], pred_taken, pred_target[31:0]}. Push when pred_valid_i & ~stall_o
//    & ~flush_o. Pop when ex_resolve_valid_i & occupancy!=0. Same-cycle push+pop allowed; count unchanged.
//  Mispredict (comb, same cycle as resolve, FIFO non-empty, head H):
//    mis = (ex_taken_i != H.pred_taken) | (ex_taken_i & ex_target_i != H.pred_target).
//    fix_pc = ex_taken_i ? ex_target_i : H.addr+4 (32-bit wrap).
//  flush_o = int_assert_i | mis (combinational). fetch_kill_o = pred_valid_i & bp_result_i
//    & ~stall_o & ~flush_o.
//  stall_o = pred_valid_i & (occupancy==DEPTH) & ~ex_resolve_valid_i (a pop frees the slot).
//  Next pc_o, strict priority:
//    1 int_assert_i -> int_addr_i; FIFO cleared.
//    2 mis          -> fix_pc; FIFO cleared (same-cycle push dropped).
//    3 stall_o      -> hold.
//    4 pred_valid_i & bp_result_i -> bp_jump_addr_i (taken redirect, independent of pc_en_i).
//    5 ~pc_en_i     -> hold.
//    6 otherwise    -> pc_o+4, wraps 32'hFFFF_FFFC -> 0.
//  Feedback: on every pop (incl. mispredict and pop in an interrupt cycle), next edge registers
//    last_need_predict_o=1, last_jump_o=ex_taken_i, last_addr_o=H.addr; strobe is 1 cycle,
//    last_jump_o/last_addr_o hold their value until the next pop.
//  Resolve with FIFO empty: no pop, no mis, err_o<=1 (cleared only by reset).
//  Interrupt + resolve same cycle: feedback still issued for the head, then FIFO cleared.
//  Reset mid-operation: immediate return to reset state; no feedback strobe emitted.
// STRUCTURE
//  Shared defines (defines.v): `ZeroWord, `InstAddrBus, `JumpEnable/`JumpDisable; add PC_INC=4.
//  One sub-module: pred_fifo (sync FIFO, DEPTH, push/pop/clear, head read, count).
//  Top: next-PC mux, mispredict compare, feedback registers, err flag.
// TESTING
//  Reset, pc_en_i=1, no preds for 3 cycles -> pc_o 0,4,8,C; flush_o=0; occupancy_o=0.
//  pred @0x10, bp taken tgt 0x40 -> fetch_kill_o=1, next pc_o=0x40; resolve taken 0x40 ->
//    flush_o=0, next cycle last_need_predict_o=1, last_jump_o=1, last_addr_o=0x10.
//  pred @0x20 not-taken, resolve taken tgt 0x80 -> flush_o=1 same cycle, pc_o=0x80 next,
//    occupancy_o=0, feedback last_jump_o=1, last_addr_o=0x20.
//  DEPTH=4: 4 unresolved preds, 5th pred_valid_i -> stall_o=1, pc held; same 5th with
//    ex_resolve_valid_i=1 (correct) -> stall_o=0, occupancy_o stays 4.
//  int_assert_i=1, int_addr_i=0x100 with mispredicting resolve same cycle -> pc_o=0x100, FIFO empty.
//  Resolve on empty FIFO -> err_o=1 sticky, pc_o unaffected; rst low mid-run -> pc_o=RESET_PC at once.

Source files
------------

// File: rtl/pc_redirect_ctrl_pkg.sv
// Shared types and constants for the next-PC / prediction-tracking stage.
// Holds the fetch address-bus constants and the in-flight prediction record.
package pc_redirect_ctrl_pkg;

    localparam logic [31:0] ZERO_WORD    = 32'h0000_0000;
    localparam logic [31:0] PC_INC       = 32'd4;
    localparam logic        JUMP_ENABLE  = 1'b1;
    localparam logic        JUMP_DISABLE = 1'b0;

    typedef logic [31:0] inst_addr_t;

    typedef struct packed {
        inst_addr_t addr;
        logic       pred_taken;
        inst_addr_t pred_target;
    } pred_entry_t;

    // Sequential successor of a fetch address; wraps naturally at 2^32.
    function automatic inst_addr_t pc_plus_inc(input inst_addr_t pc);
        return pc + PC_INC;
    endfunction

endpackage

// File: rtl/pc_redirect_ctrl_if.sv
// Signal bundle between bpu/decode/execute and the next-PC stage.
// pred_valid_i offers a prediction; stall_o low is its ready. A prediction
// is taken only in a cycle where pred_valid_i=1 and stall_o=0 and flush_o=0.
interface pc_redirect_ctrl_if #(parameter int DEPTH = 4);

    localparam int OCC_W = $clog2(DEPTH) + 1;

    logic             pc_en_i;
    logic             pred_valid_i;
    logic [31:0]      inst_addr_i;
    logic             bp_result_i;
    logic [31:0]      bp_jump_addr_i;
    logic             ex_resolve_valid_i;
    logic             ex_taken_i;
    logic [31:0]      ex_target_i;
    logic             int_assert_i;
    logic [31:0]      int_addr_i;
    logic [31:0]      pc_o;
    logic             fetch_kill_o;
    logic             flush_o;
    logic             stall_o;
    logic             last_jump_o;
    logic [31:0]      last_addr_o;
    logic             last_need_predict_o;
    logic [OCC_W-1:0] occupancy_o;
    logic             err_o;

    modport slave (
        input  pc_en_i, pred_valid_i, inst_addr_i, bp_result_i, bp_jump_addr_i,
               ex_resolve_valid_i, ex_taken_i, ex_target_i, int_assert_i, int_addr_i,
        output pc_o, fetch_kill_o, flush_o, stall_o, last_jump_o, last_addr_o,
               last_need_predict_o, occupancy_o, err_o
    );

    modport master (
        output pc_en_i, pred_valid_i, inst_addr_i, bp_result_i, bp_jump_addr_i,
               ex_resolve_valid_i, ex_taken_i, ex_target_i, int_assert_i, int_addr_i,
        input  pc_o, fetch_kill_o, flush_o, stall_o, last_jump_o, last_addr_o,
               last_need_predict_o, occupancy_o, err_o
    );

endinterface

// File: rtl/pc_redirect_ctrl_pred_fifo.sv
// In-flight prediction queue: synchronous FIFO with clear, head peek and count.
// Caller never pushes into a full FIFO without a same-cycle pop.
module pc_redirect_ctrl_pred_fifo
    import pc_redirect_ctrl_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      push,
    input  logic                      pop,
    input  logic                      clear,
    input  pred_entry_t               din,
    output pred_entry_t               head,
    output logic [$clog2(DEPTH):0]    count
);

    localparam int AW = $clog2(DEPTH);

    pred_entry_t   mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;

    always_ff @(posedge clk) begin
        if (push && !clear) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    assign head = mem[rd_ptr];

endmodule

// File: rtl/pc_redirect_ctrl.sv
// Next-PC selection, mispredict repair and bpu training feedback.
// Every issued prediction is queued until execute resolves it in order.
module pc_redirect_ctrl
    import pc_redirect_ctrl_pkg::*;
#(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic           clk,
    input  logic           rst,
    pc_redirect_ctrl_if.slave bus
);

    localparam int OCC_W = $clog2(DEPTH) + 1;

    pred_entry_t      head;
    pred_entry_t      new_entry;
    logic [OCC_W-1:0] count;
    logic             has_entry;
    logic             pop;
    logic             push;
    logic             mis;
    logic             flush;
    logic             stall;
    inst_addr_t       fix_pc;
    inst_addr_t       pc_q;
    inst_addr_t       pc_next;
    logic             last_jump_q;
    inst_addr_t       last_addr_q;
    logic             last_need_q;
    logic             err_q;

    assign has_entry = (count != '0);
    assign pop       = bus.ex_resolve_valid_i & has_entry;

    // A mispredict is only meaningful against a real head entry.
    assign mis = pop & ((bus.ex_taken_i != head.pred_taken) |
                        (bus.ex_taken_i & (bus.ex_target_i != head.pred_target)));
    assign fix_pc = bus.ex_taken_i ? bus.ex_target_i : pc_plus_inc(head.addr);

    assign flush = bus.int_assert_i | mis;
    // A same-cycle resolve frees a slot, so a full FIFO only stalls without one.
    assign stall = bus.pred_valid_i & (count == OCC_W'(DEPTH)) & ~bus.ex_resolve_valid_i;
    assign push  = bus.pred_valid_i & ~stall & ~flush;

    assign new_entry = '{addr:        bus.inst_addr_i,
                         pred_taken:  bus.bp_result_i,
                         pred_target: bus.bp_jump_addr_i};

    pc_redirect_ctrl_pred_fifo #(.DEPTH(DEPTH)) u_pred_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .clear (flush),
        .din   (new_entry),
        .head  (head),
        .count (count)
    );

    always_comb begin
        pc_next = pc_q;
        if (bus.int_assert_i) begin
            pc_next = bus.int_addr_i;
        end else if (mis) begin
            pc_next = fix_pc;
        end else if (stall) begin
            pc_next = pc_q;
        end else if (bus.pred_valid_i && bus.bp_result_i) begin
            pc_next = bus.bp_jump_addr_i;
        end else if (!bus.pc_en_i) begin
            pc_next = pc_q;
        end else begin
            pc_next = pc_plus_inc(pc_q);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc_q        <= RESET_PC;
            last_jump_q <= JUMP_DISABLE;
            last_addr_q <= ZERO_WORD;
            last_need_q <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            pc_q        <= pc_next;
            last_need_q <= pop;
            if (pop) begin
                last_jump_q <= bus.ex_taken_i;
                last_addr_q <= head.addr;
            end
            if (bus.ex_resolve_valid_i && !has_entry) begin
                err_q <= 1'b1;
            end
        end
    end

    assign bus.pc_o                = pc_q;
    assign bus.fetch_kill_o        = push & bus.bp_result_i;
    assign bus.flush_o             = flush;
    assign bus.stall_o             = stall;
    assign bus.last_jump_o         = last_jump_q;
    assign bus.last_addr_o         = last_addr_q;
    assign bus.last_need_predict_o = last_need_q;
    assign bus.occupancy_o         = count;
    assign bus.err_o               = err_q;

endmodule

// File: tb/tb_pc_redirect_ctrl.sv
// Directed bench for pc_redirect_ctrl: a table of per-cycle stimulus with
// hand-computed expectations, plus an asynchronous mid-run reset sequence.
module tb_pc_redirect_ctrl;

    localparam int DEPTH = 4;

    logic clk;
    logic rst;

    pc_redirect_ctrl_if #(.DEPTH(DEPTH)) ifc ();

    pc_redirect_ctrl #(.DEPTH(DEPTH), .RESET_PC(32'h0000_0000)) dut (
        .clk (clk),
        .rst (rst),
        .bus (ifc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        pc_en;
        logic        pred_v;
        logic [31:0] iaddr;
        logic        bp_res;
        logic [31:0] bp_tgt;
        logic        res_v;
        logic        taken;
        logic [31:0] tgt;
        logic        intr;
        logic [31:0] int_addr;
        logic        e_flush;
        logic        e_kill;
        logic        e_stall;
        logic [31:0] e_pc;
        logic [31:0] e_occ;
        logic        e_lnp;
        logic        e_lj;
        logic [31:0] e_la;
        logic        e_err;
    } vec_t;

    vec_t vecs[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    task automatic chk(input string name, input int step, input logic [31:0] act,
                       input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s step %0d: got 0x%08h expected 0x%08h", name, step, act, exp);
    endtask

    // Stimulus-and-expectation record: inputs first, then comb outputs, then post-edge state.
    function automatic vec_t mk(
        input logic pc_en, input logic pv, input logic [31:0] ia, input logic bp,
        input logic [31:0] bt, input logic rv, input logic tk, input logic [31:0] tg,
        input logic it, input logic [31:0] iad,
        input logic ef, input logic ek, input logic es,
        input logic [31:0] epc, input int eocc, input logic elnp, input logic elj,
        input logic [31:0] ela, input logic eerr);
        vec_t v;
        v.pc_en = pc_en; v.pred_v = pv; v.iaddr = ia; v.bp_res = bp; v.bp_tgt = bt;
        v.res_v = rv; v.taken = tk; v.tgt = tg; v.intr = it; v.int_addr = iad;
        v.e_flush = ef; v.e_kill = ek; v.e_stall = es; v.e_pc = epc;
        v.e_occ = 32'(eocc); v.e_lnp = elnp; v.e_lj = elj; v.e_la = ela; v.e_err = eerr;
        return v;
    endfunction

    task automatic drive(input vec_t v);
        ifc.pc_en_i            = v.pc_en;
        ifc.pred_valid_i       = v.pred_v;
        ifc.inst_addr_i        = v.iaddr;
        ifc.bp_result_i        = v.bp_res;
        ifc.bp_jump_addr_i     = v.bp_tgt;
        ifc.ex_resolve_valid_i = v.res_v;
        ifc.ex_taken_i         = v.taken;
        ifc.ex_target_i        = v.tgt;
        ifc.int_assert_i       = v.intr;
        ifc.int_addr_i         = v.int_addr;
    endtask

    task automatic check_regs(input int step, input logic [31:0] pc, input logic [31:0] occ,
                              input logic lnp, input logic lj, input logic [31:0] la,
                              input logic err);
        chk("pc_o", step, ifc.pc_o, pc);
        chk("occupancy_o", step, 32'(ifc.occupancy_o), occ);
        chk("last_need_predict_o", step, 32'(ifc.last_need_predict_o), 32'(lnp));
        chk("last_jump_o", step, 32'(ifc.last_jump_o), 32'(lj));
        chk("last_addr_o", step, ifc.last_addr_o, la);
        chk("err_o", step, 32'(ifc.err_o), 32'(err));
    endtask

    initial begin
        vec_t idle;
        idle = mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

        //        en pv iaddr         bp bp_tgt        rv tk target        it int_addr    fl ki st pc             oc lnp lj last_addr     err
        vecs.push_back(mk(1, 0, 32'h0,     0, 32'h0,     0, 0, 32'h0,     0, 32'h0,   0, 0, 0, 32'h4,     0, 0, 0, 32'h0,   0));
        vecs.push_back(mk(1, 0, 32'h0,     0, 32'h0,     0, 0, 32'h0,     0, 32'h0,   0, 0, 0, 32'h8,     0, 0, 0, 32'h0,   0));
        vecs.push_back(mk(1, 0, 32'h0,     0, 32'h0,     0, 0, 32'h0,     0, 32'h0,   0, 0, 0, 32'hC,     0, 0, 0, 32'h0,   0));
        vecs.push_back(mk(1, 1, 32'h10,    1, 32'h40,    0, 0, 32'h0,     0, 32'h0,   0, 1, 0, 32'h40,    1, 0, 0, 32'h0,   0));
        vecs.push_back(mk(1, 0, 32'h0,     0, 32'h0,     1, 1, 32'h40,    0, 32'h0,   0, 0, 0, 32'h44,    0, 1, 1, 32'h10,  0));
        vecs.push_back(mk(1, 1, 32'h20,    0, 32'h0,     0, 0, 32'h0,     0, 32'h0,   0, 0, 0, 32'h48,    1, 0, 1, 32'h10,  0));
        vecs.push_back(mk(1, 0, 32'h0,     0, 32'h0,     1, 1, 32'h80,    0, 32'h0,   1, 0, 0, 32'h80,    0, 1, 1, 32'h20,  0));
        vecs.push_back(mk(0, 0, 32'h0,     0, 32'h0,     0, 0, 32'h0,     0, 32'h0,   0, 0, 0, 32'h80,    0, 0, 1, 32'h20,  0));
        // fill the FIFO: four unresolved predictions, the last one with pc_en low
        vecs.push_back(mk(1, 1, 32'h100,   0, 32'h0,     0, 0, 32'h0,     0, 32'h0,   0, 0, 0, 32'h84,    1, 0, 1, 32'h20,  0));
        vecs.push_back(mk(1, 1, 32'h104,   1, 32'h200,   0, 0, 32'h0,     0, 32'h0,   0, 1, 0, 32'h200,   2, 0, 1, 32'h20,  0));
        vecs.push_back(mk(1, 1, 32'h200,   0, 32'h0,     0, 0, 32'h0,     0, 32'h0,   0, 0, 0, 32'h204,   3, 0, 1, 32'h20,  0));
        vecs.push_back(mk(0, 1, 32'h204,   1, 32'h300,   0, 0, 32'h0,     0, 32'h0,   0, 1, 0, 32'h300,   4, 0, 1, 32'h20,  0));
        vecs.push_back(mk(1, 1, 32'h300,   1, 32'h400,   0, 0, 32'h0,     0, 32'h0,   0, 0, 1, 32'h300,   4, 0, 1, 32'h20,  0));
        vecs.push_back(mk(1, 1, 32'h300,   1, 32'h400,   1, 0, 32'h0,     0, 32'h0,   0, 1, 0, 32'h400,   4, 1, 0, 32'h100, 0));
        vecs.push_back(mk(1, 0, 32'h0,     0, 32'h0,     1, 1, 32'h200,   0, 32'h0,   0, 0, 0, 32'h404,   3, 1, 1, 32'h104, 0));
        // interrupt with a mispredicting resolve and a dropped same-cycle prediction
        vecs.push_back(mk(1, 1, 32'h404,   1, 32'h600,   1, 1, 32'h500,   1, 32'h100, 1, 0, 0, 32'h100,   0, 1, 1, 32'h200, 0));
        vecs.push_back(mk(0, 0, 32'h0,     0, 32'h0,     1, 1, 32'h900,   0, 32'h0,   0, 0, 0, 32'h100,   0, 0, 1, 32'h200, 1));
        vecs.push_back(mk(1, 0, 32'h0,     0, 32'h0,     0, 0, 32'h0,     0, 32'h0,   0, 0, 0, 32'h104,   0, 0, 1, 32'h200, 1));
        // taken/taken with wrong target, then predicted-taken resolved not-taken
        vecs.push_back(mk(1, 1, 32'h104,   1, 32'h700,   0, 0, 32'h0,     0, 32'h0,   0, 1, 0, 32'h700,   1, 0, 1, 32'h200, 1));
        vecs.push_back(mk(1, 0, 32'h0,     0, 32'h0,     1, 1, 32'h710,   0, 32'h0,   1, 0, 0, 32'h710,   0, 1, 1, 32'h104, 1));
        vecs.push_back(mk(1, 1, 32'h710,   1, 32'h800,   0, 0, 32'h0,     0, 32'h0,   0, 1, 0, 32'h800,   1, 0, 1, 32'h104, 1));
        vecs.push_back(mk(1, 0, 32'h0,     0, 32'h0,     1, 0, 32'h0,     0, 32'h0,   1, 0, 0, 32'h714,   0, 1, 0, 32'h710, 1));
        // sequential wrap from 0xFFFF_FFFC
        vecs.push_back(mk(1, 1, 32'h714,   1, 32'hFFFF_FFFC, 0, 0, 32'h0, 0, 32'h0,   0, 1, 0, 32'hFFFF_FFFC, 1, 0, 0, 32'h710, 1));
        vecs.push_back(mk(1, 0, 32'h0,     0, 32'h0,     0, 0, 32'h0,     0, 32'h0,   0, 0, 0, 32'h0,     1, 0, 0, 32'h710, 1));
        vecs.push_back(mk(1, 0, 32'h0,     0, 32'h0,     1, 1, 32'hFFFF_FFFC, 0, 32'h0, 0, 0, 0, 32'h4,   0, 1, 1, 32'h714, 1));

        rst = 1'b0;
        drive(idle);
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("flush_o_reset", 0, 32'(ifc.flush_o), 32'h0);
        chk("stall_o_reset", 0, 32'(ifc.stall_o), 32'h0);
        chk("fetch_kill_o_reset", 0, 32'(ifc.fetch_kill_o), 32'h0);
        check_regs(0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
        rst = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            if (i != 0) @(negedge clk);
            drive(vecs[i]);
            #1;
            chk("flush_o", i + 1, 32'(ifc.flush_o), 32'(vecs[i].e_flush));
            chk("fetch_kill_o", i + 1, 32'(ifc.fetch_kill_o), 32'(vecs[i].e_kill));
            chk("stall_o", i + 1, 32'(ifc.stall_o), 32'(vecs[i].e_stall));
            @(posedge clk);
            #1;
            check_regs(i + 1, vecs[i].e_pc, vecs[i].e_occ, vecs[i].e_lnp, vecs[i].e_lj,
                       vecs[i].e_la, vecs[i].e_err);
        end

        // Asynchronous reset while the feedback strobe, err_o and last_* are all set.
        @(negedge clk);
        drive(idle);
        #2;
        rst = 1'b0;
        #1;
        check_regs(100, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
        @(posedge clk);
        #1;
        check_regs(101, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check_regs(102, 32'h4, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish, got %0d/%0d", n_pass, n_checks);
        $fatal(1);
    end

endmodule
